alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute stage ALU; consumer of the 5-bit ALUSignal code from the ALU control decoder.
//  Takes op code + two 32-bit operands over valid/ready, returns result + zero flag over valid/ready.
//  Arithmetic/logic/compare ops: 1 cycle; shifts: iterative 1 bit/cycle unless barrel shifter compiled in.
//  zero flag drives BEQ (SUB result == 0) in the branch path.
// PARAMETERS
//  XLEN     32  operand/result width (shift amount = low $clog2(XLEN) bits of op_b)
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  in_valid   in   1     op_code/op_a/op_b valid
//  in_ready   out  1     unit can accept a new op
//  op_code    in   5     ALUSignal: ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9
//  op_a       in   XLEN  rs1 / PC operand
//  op_b       in   XLEN  rs2 / immediate operand
//  out_valid  out  1     result/zero/illegal valid
//  out_ready  in   1     consumer takes result
//  result     out  XLEN  ALU result
//  zero       out  1     result == 0
//  illegal    out  1     op_code outside 0..9 (result forced 0)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, illegal=0.
//  - FSM IDLE -> (accept, shift op, shamt>0) SHIFT; IDLE -> (accept, other op or shamt=0) DONE;
//    SHIFT -> (count reaches 0) DONE; DONE -> (out_ready) IDLE. No other transitions.
//  - Accept = in_valid & in_ready; in_ready=1 only in IDLE. Inputs sampled only on accept.
//  - Non-shift op accepted cycle N -> out_valid=1 from cycle N+1.
//  - Shift by k (1..XLEN-1) accepted cycle N -> SHIFT for k cycles, out_valid from N+1+k.
//  - SRA shifts in op_a[XLEN-1]; SLL/SRL shift in 0. shamt=0 -> result=op_a, latency 1.
//  - ADD/SUB modulo 2^XLEN, no overflow flag. SLT signed, SLTU unsigned; result 0/1 zero-extended.
//  - Illegal code (10..31): illegal=1, result=0, zero=1, latency 1; no other side effect.
//  - DONE holds result/zero/illegal stable while out_valid & !out_ready (no back-to-back accept).
//  - out_valid falls the cycle after out_valid & out_ready; in_ready rises same cycle.
//  - in_valid while busy: ignored, not queued; source must hold until in_ready.
//  - zero, illegal registered together with result; never change while out_valid=1.
// CONFIGURATION
//  - ALU_BARREL_SHIFT_EN defined: shifts computed combinationally, all legal ops latency 1,
//    SHIFT state and shift counter removed.
//  - Undefined (default): iterative shifter as above, latency 1+shamt.
// STRUCTURE
//  - Shared package alu_pkg: ALU op code localparams (ADD..AND, 5-bit), FSM state enum
//    (IDLE, SHIFT, DONE), XLEN default, shamt width constant; also used by ALU control decoder.
//  - One sub-module: alu_shifter (iterative 1-bit/cycle shifter with counter; barrel variant
//    under ALU_BARREL_SHIFT_EN). Everything else flat in alu_exec_unit.
// TESTING
//  - ADD 0x7FFFFFFF+1 -> result 0x80000000, zero=0, out_valid one cycle after accept.
//  - SUB 5-5 -> result 0, zero=1; SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0.
//  - SRA 0x80000000 by 4 -> 0xF8000000 after 5 cycles (1 cycle with ALU_BARREL_SHIFT_EN);
//    SLL by 0 -> op_a after 1 cycle; in_ready=0 throughout SHIFT.
//  - out_ready held 0 for 3 cycles at DONE -> result/zero stable, in_valid pulses ignored,
//    accept only after handshake completes.
//  - op_code 5'd12 -> illegal=1, result=0, zero=1; next legal op clears illegal.
//  - rst asserted mid-SHIFT (asynchronously) -> outputs to reset values immediately, next op
//    after release executes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, FSM states and width constants.
// Also used by the ALU control decoder.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int SHAMT_W      = $clog2(XLEN_DEFAULT);

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    function automatic logic is_shift(input logic [4:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_if.sv
// Valid/ready request and response bundle of the execute-stage ALU.
// master drives operands and out_ready; slave is the ALU.
interface alu_if #(
    parameter int XLEN = alu_pkg::XLEN_DEFAULT
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op_code;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, op_code, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, op_code, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_shifter.sv
// Shifter for SLL/SRL/SRA: iterative 1 bit/cycle by default,
// combinational barrel shifter when ALU_BARREL_SHIFT_EN is defined.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
)
`ifdef ALU_BARREL_SHIFT_EN
(
    input  logic [4:0]              op,
    input  logic [XLEN-1:0]         din,
    input  logic [$clog2(XLEN)-1:0] shamt,
    output logic [XLEN-1:0]         dout
);

    always_comb begin
        dout = din;
        case (op)
            ALU_SLL: dout = din << shamt;
            ALU_SRL: dout = din >> shamt;
            ALU_SRA: dout = $signed(din) >>> shamt;
            default: dout = din;
        endcase
    end

`else
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4:0]              op,
    input  logic [XLEN-1:0]         din,
    input  logic [$clog2(XLEN)-1:0] shamt,
    output logic                    last,
    output logic [XLEN-1:0]         dout
);

    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] val_q;
    logic [XLEN-1:0] nxt;
    logic [SW-1:0]   cnt_q;
    logic [4:0]      op_q;

    always_comb begin
        nxt = {1'b0, val_q[XLEN-1:1]};
        case (op_q)
            ALU_SLL: nxt = {val_q[XLEN-2:0], 1'b0};
            ALU_SRA: nxt = {val_q[XLEN-1], val_q[XLEN-1:1]};
            default: nxt = {1'b0, val_q[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
            cnt_q <= '0;
            op_q  <= ALU_SRL;
        end else if (load) begin
            val_q <= din;
            cnt_q <= shamt;
            op_q  <= op;
        end else if (cnt_q != '0) begin
            val_q <= nxt;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // dout is the value after the step taken on the cycle last is high
    assign last = (cnt_q == SW'(1));
    assign dout = nxt;

`endif
endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready in and out, registered result/zero/illegal.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts (no SHIFT state).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input logic  clk,
    input logic  rst,
    alu_if.slave bus
);

    localparam int SW = $clog2(XLEN);

    state_t          state;
    logic            accept;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic [XLEN-1:0] sh_dout;

    assign accept = bus.in_valid & bus.in_ready;
    assign shamt  = bus.op_b[SW-1:0];

`ifdef ALU_BARREL_SHIFT_EN
    alu_shifter #(.XLEN(XLEN)) u_shifter (
        .op    (bus.op_code),
        .din   (bus.op_a),
        .shamt (shamt),
        .dout  (sh_dout)
    );
`else
    logic go_shift;
    logic sh_last;

    assign go_shift = accept & is_shift(bus.op_code) & (shamt != '0);

    alu_shifter #(.XLEN(XLEN)) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (go_shift),
        .op    (bus.op_code),
        .din   (bus.op_a),
        .shamt (shamt),
        .last  (sh_last),
        .dout  (sh_dout)
    );
`endif

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (bus.op_code)
            ALU_ADD:  alu_res = bus.op_a + bus.op_b;
            ALU_SUB:  alu_res = bus.op_a - bus.op_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}},
                                 $signed(bus.op_a) < $signed(bus.op_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
            ALU_XOR:  alu_res = bus.op_a ^ bus.op_b;
            ALU_OR:   alu_res = bus.op_a | bus.op_b;
            ALU_AND:  alu_res = bus.op_a & bus.op_b;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = sh_dout;
`else
            // only reached here with shamt == 0
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = bus.op_a;
`endif
            default:  alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.zero      <= 1'b1;
            bus.illegal   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.in_ready <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
                        if (go_shift) begin
                            state <= SHIFT;
                        end else
`endif
                        begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.result    <= alu_res;
                            bus.zero      <= (alu_res == '0);
                            bus.illegal   <= alu_ill;
                        end
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                SHIFT: begin
                    if (sh_last) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.result    <= sh_dout;
                        bus.zero      <= (sh_dout == '0);
                        bus.illegal   <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit (default and ALU_BARREL_SHIFT_EN builds).
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    alu_if #(.XLEN(32)) bus ();

    alu_exec_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat,
                         output logic busy_ok);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        bus.op_code  = op;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) busy_ok = 1'b0;
            step();
            lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        else passed++;
        total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        else passed++;
        total++;
        if (bus.result !== 32'h0 || bus.zero !== 1'b1 || bus.illegal !== 1'b0)
            $display("FAIL reset_outputs: got res=%h z=%b ill=%b want 0/1/0",
                     bus.result, bus.zero, bus.illegal);
        else passed++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_arith();
        logic [4:0]  ops [9] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR,
                                 ALU_OR, ALU_AND, ALU_ADD, ALU_SUB};
        logic [31:0] av [9] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'hF0F0F0F0, 32'h0000F000, 32'hF0F0F0F0,
                                32'hFFFFFFFF, 32'h0};
        logic [31:0] bv [9] = '{32'h1, 32'd5, 32'h1, 32'h1, 32'hFF00FF00,
                                32'h0000000F, 32'hFF00FF00, 32'h1, 32'h1};
        logic [31:0] rv [9] = '{32'h80000000, 32'h0, 32'h1, 32'h0, 32'h0FF00FF0,
                                32'h0000F00F, 32'hF000F000, 32'h0, 32'hFFFFFFFF};
        int   lat;
        logic bok;
        for (int i = 0; i < 9; i++) begin
            issue(ops[i], av[i], bv[i], lat, bok);
            total++;
            if (bus.result !== rv[i])
                $display("FAIL arith[%0d]_result: got %h want %h", i, bus.result, rv[i]);
            else passed++;
            total++;
            if (bus.zero !== (rv[i] == 32'h0) || bus.illegal !== 1'b0)
                $display("FAIL arith[%0d]_flags: got z=%b ill=%b want z=%b ill=0",
                         i, bus.zero, bus.illegal, rv[i] == 32'h0);
            else passed++;
            total++;
            if (lat !== 1)
                $display("FAIL arith[%0d]_latency: got %0d want 1", i, lat);
            else passed++;
            consume();
        end
    endtask

    task automatic test_shift();
        logic [4:0]  ops [6] = '{ALU_SRA, ALU_SLL, ALU_SRL, ALU_SLL, ALU_SRA, ALU_SRA};
        logic [31:0] av [6] = '{32'h80000000, 32'h12345678, 32'h80000000,
                                32'h00000001, 32'h7FFFFFFF, 32'h80000000};
        logic [31:0] bv [6] = '{32'd4, 32'd0, 32'd31, 32'd31, 32'd1, 32'h24};
        logic [31:0] rv [6] = '{32'hF8000000, 32'h12345678, 32'h00000001,
                                32'h80000000, 32'h3FFFFFFF, 32'hF8000000};
        int   kv [6] = '{4, 0, 31, 31, 1, 4};
        int   lat;
        int   want;
        logic bok;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], av[i], bv[i], lat, bok);
`ifdef ALU_BARREL_SHIFT_EN
            want = 1;
`else
            want = kv[i] + 1;
`endif
            total++;
            if (bus.result !== rv[i])
                $display("FAIL shift[%0d]_result: got %h want %h", i, bus.result, rv[i]);
            else passed++;
            total++;
            if (lat !== want)
                $display("FAIL shift[%0d]_latency: got %0d want %0d", i, lat, want);
            else passed++;
            total++;
            if (bok !== 1'b1 || bus.zero !== (rv[i] == 32'h0))
                $display("FAIL shift[%0d]_busy_zero: got busy_ok=%b z=%b want 1/%b",
                         i, bok, bus.zero, rv[i] == 32'h0);
            else passed++;
            consume();
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        logic bok;
        issue(ALU_SUB, 32'd9, 32'd9, lat, bok);
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1;
            bus.op_code  = (c == 1) ? ALU_SLL : ALU_ADD;
            bus.op_a     = 32'd1;
            bus.op_b     = (c == 1) ? 32'd5 : 32'd2;
            step();
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.result !== 32'h0 || bus.zero !== 1'b1)
                $display("FAIL hold[%0d]: got v=%b rdy=%b res=%h z=%b want 1/0/0/1",
                         c, bus.out_valid, bus.in_ready, bus.result, bus.zero);
            else passed++;
        end
        bus.op_code   = ALU_ADD;
        bus.op_b      = 32'd2;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL handshake: got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
        else passed++;
        step();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || bus.result !== 32'd3)
            $display("FAIL post_hold_accept: got v=%b res=%h want 1/3",
                     bus.out_valid, bus.result);
        else passed++;
        consume();
    endtask

    task automatic test_illegal();
        int   lat;
        logic bok;
        issue(5'd12, 32'd123, 32'd456, lat, bok);
        total++;
        if (bus.illegal !== 1'b1 || bus.result !== 32'h0 || bus.zero !== 1'b1 || lat !== 1)
            $display("FAIL illegal_12: got ill=%b res=%h z=%b lat=%0d want 1/0/1/1",
                     bus.illegal, bus.result, bus.zero, lat);
        else passed++;
        consume();
        issue(ALU_ADD, 32'd2, 32'd3, lat, bok);
        total++;
        if (bus.illegal !== 1'b0 || bus.result !== 32'd5)
            $display("FAIL illegal_clear: got ill=%b res=%h want 0/5", bus.illegal, bus.result);
        else passed++;
        consume();
        issue(5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bok);
        total++;
        if (bus.illegal !== 1'b1 || bus.result !== 32'h0)
            $display("FAIL illegal_31: got ill=%b res=%h want 1/0", bus.illegal, bus.result);
        else passed++;
        consume();
    endtask

    task automatic test_reset_mid_shift();
        int   lat;
        logic bok;
        bus.op_code  = ALU_SRL;
        bus.op_a     = 32'hFFFF0000;
        bus.op_b     = 32'd20;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 32'h0 ||
            bus.zero !== 1'b1 || bus.illegal !== 1'b0)
            $display("FAIL async_reset: got v=%b rdy=%b res=%h z=%b ill=%b want 0/1/0/1/0",
                     bus.out_valid, bus.in_ready, bus.result, bus.zero, bus.illegal);
        else passed++;
        step();
        rst = 1'b0;
        step();
        issue(ALU_ADD, 32'h10, 32'h20, lat, bok);
        total++;
        if (bus.result !== 32'h30 || lat !== 1)
            $display("FAIL after_reset_add: got res=%h lat=%0d want 30/1", bus.result, lat);
        else passed++;
        consume();
        issue(ALU_SRL, 32'hFFFF0000, 32'd20, lat, bok);
        total++;
        if (bus.result !== 32'h00000FFF)
            $display("FAIL after_reset_srl: got %h want 00000fff", bus.result);
        else passed++;
        consume();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op_code   = 5'd0;
        bus.op_a      = 32'h0;
        bus.op_b      = 32'h0;
        bus.out_ready = 1'b0;
        test_reset();
        test_arith();
        test_shift();
        test_backpressure();
        test_illegal();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
